// File: rtl/pc_sequencer.sv
// Program counter with a shift-register return/data stack for a small sequencing core.
// Optional sticky overflow/underflow flags are built only when PC_STACK_FLAGS_EN is defined.
module pc_sequencer #(
    parameter int AW    = 12,
    parameter int DEPTH = 4,
    parameter int STEP  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     branch_en,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic                     push_en,
    input  logic                     pop_en,
    input  logic [AW-1:0]            target,
    input  logic [AW-1:0]            push_data,
    input  logic                     flag_clear,
    output logic [AW-1:0]            pc,
    output logic [AW-1:0]            stack_top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int              DW     = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0]   STEP_V = AW'(STEP);
    localparam logic [DW-1:0]   FULL   = DW'(DEPTH);

    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic [AW-1:0] stack_q [DEPTH];
    logic [AW-1:0] stack_d [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic          do_push, do_pop;
    logic [AW-1:0] push_val;
    logic          ovf_set, unf_set;

    // One command per cycle; ret > call > branch > pop > push.
    always_comb begin
        pc_inc   = pc_q + STEP_V;
        pc_d     = pc_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_val = push_data;
        if (!stall) begin
            if (ret_en) begin
                pc_d   = stack_q[0];
                do_pop = 1'b1;
            end else if (call_en) begin
                pc_d     = target;
                do_push  = 1'b1;
                push_val = pc_inc;
            end else if (branch_en) begin
                pc_d = target;
            end else if (pop_en) begin
                pc_d   = pc_inc;
                do_pop = 1'b1;
            end else if (push_en) begin
                pc_d    = pc_inc;
                do_push = 1'b1;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Push drops the deepest entry when full; pop keeps the bottom entry in place.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (do_push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stack_d[i] = stack_q[i-1];
            end
            stack_d[0] = push_val;
            if (depth_q == FULL) begin
                ovf_set = 1'b1;
            end else begin
                depth_d = depth_q + DW'(1);
            end
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                stack_d[i] = stack_q[i+1];
            end
            if (depth_q == '0) begin
                unf_set = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            stack_q <= stack_d;
        end
    end

`ifdef PC_STACK_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Clear beats a same-cycle set; stall freezes the flags too.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!stall) begin
            if (flag_clear) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end else begin
                ovf_d = ovf_q | ovf_set;
                unf_d = unf_q | unf_set;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_flags;
    assign unused_flags = ^{flag_clear, ovf_set, unf_set};
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
`endif

    assign pc        = pc_q;
    assign stack_top = stack_q[0];
    assign depth     = depth_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, mid-cycle reset sequence, then random
// traffic against a queue-based model of the stack.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int STEP  = 2;
    localparam int DW    = $clog2(DEPTH) + 1;
`ifdef PC_STACK_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // command bits
    localparam int S = 1, B = 2, C = 4, R = 8, P = 16, O = 32, F = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0, branch_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic          push_en = 1'b0, pop_en = 1'b0, flag_clear = 1'b0;
    logic [AW-1:0] target = '0, push_data = '0;
    logic [AW-1:0] pc, stack_top;
    logic [DW-1:0] depth;
    logic          overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
        .call_en(call_en), .ret_en(ret_en), .push_en(push_en), .pop_en(pop_en),
        .target(target), .push_data(push_data), .flag_clear(flag_clear),
        .pc(pc), .stack_top(stack_top), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cmd;
        int tgt;
        int pd;
        int e_pc;
        int e_top;
        int e_dep;
        bit e_ovf;
        bit e_unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int cmd, int tgt, int pd, int e_pc, int e_top, int e_dep,
                               bit e_ovf, bit e_unf);
        vec_t r;
        r.cmd = cmd; r.tgt = tgt; r.pd = pd; r.e_pc = e_pc; r.e_top = e_top;
        r.e_dep = e_dep; r.e_ovf = e_ovf; r.e_unf = e_unf;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int e_pc, int e_top, int e_dep, bit e_ovf, bit e_unf);
        check({tag, "/pc"}, int'(pc), e_pc);
        check({tag, "/top"}, int'(stack_top), e_top);
        check({tag, "/depth"}, int'(depth), e_dep);
        check({tag, "/ovf"}, int'(overflow), int'(FLAGS & e_ovf));
        check({tag, "/unf"}, int'(underflow), int'(FLAGS & e_unf));
    endtask

    task automatic apply(int cmd, int tgt, int pd);
        stall      = (cmd & S) != 0;
        branch_en  = (cmd & B) != 0;
        call_en    = (cmd & C) != 0;
        ret_en     = (cmd & R) != 0;
        push_en    = (cmd & P) != 0;
        pop_en     = (cmd & O) != 0;
        flag_clear = (cmd & F) != 0;
        target     = AW'(tgt);
        push_data  = AW'(pd);
    endtask

    // Reference model: stack as a fixed-length queue, index 0 = top.
    int m_pc;
    int m_stk[$];
    int m_dep;
    bit m_ovf, m_unf;

    function automatic void m_reset();
        m_pc = 0; m_dep = 0; m_ovf = 0; m_unf = 0;
        m_stk = {};
        for (int i = 0; i < DEPTH; i++) m_stk.push_back(0);
    endfunction

    function automatic void m_step(int cmd, int tgt, int pd);
        bit so, su;
        int nxt, last;
        so = 0; su = 0;
        if ((cmd & S) != 0) return;
        nxt = (m_pc + STEP) % (1 << AW);
        if ((cmd & (R | O)) != 0 && (cmd & (C | B)) == 0 || (cmd & R) != 0) begin
            if ((cmd & R) != 0) m_pc = m_stk[0];
            else                m_pc = nxt;
            last = m_stk[DEPTH-1];
            void'(m_stk.pop_front());
            m_stk.push_back(last);
            if (m_dep == 0) su = 1; else m_dep--;
        end else if ((cmd & (C | P)) != 0 && (cmd & B) == 0 || (cmd & C) != 0) begin
            m_stk.push_front(((cmd & C) != 0) ? nxt : pd);
            void'(m_stk.pop_back());
            m_pc = ((cmd & C) != 0) ? tgt : nxt;
            if (m_dep == DEPTH) so = 1; else m_dep++;
        end else if ((cmd & B) != 0) begin
            m_pc = tgt;
        end else begin
            m_pc = nxt;
        end
        if (FLAGS) begin
            if ((cmd & F) != 0) begin
                m_ovf = 0; m_unf = 0;
            end else begin
                m_ovf |= so; m_unf |= su;
            end
        end
    endfunction

    initial begin
        int cmd, tgt, pd;

        // reset asserted asynchronously, between clock edges
        #2 reset = 1'b1;
        #1 check_all("reset", 0, 0, 0, 0, 0);

        //            cmd              tgt    pd     pc     top    dep ovf unf
        tbl.push_back(v(0,             0,     0,     'h002, 'h000, 0, 0, 0));
        tbl.push_back(v(0,             0,     0,     'h004, 'h000, 0, 0, 0));
        tbl.push_back(v(0,             0,     0,     'h006, 'h000, 0, 0, 0));
        tbl.push_back(v(B,             'h010, 0,     'h010, 'h000, 0, 0, 0));
        tbl.push_back(v(C,             'h100, 0,     'h100, 'h012, 1, 0, 0));
        tbl.push_back(v(R,             0,     0,     'h012, 'h000, 0, 0, 0));
        tbl.push_back(v(P,             0,     'h001, 'h014, 'h001, 1, 0, 0));
        tbl.push_back(v(P,             0,     'h002, 'h016, 'h002, 2, 0, 0));
        tbl.push_back(v(P,             0,     'h003, 'h018, 'h003, 3, 0, 0));
        tbl.push_back(v(P,             0,     'h004, 'h01A, 'h004, 4, 0, 0));
        tbl.push_back(v(P,             0,     'h005, 'h01C, 'h005, 4, 1, 0));
        tbl.push_back(v(O,             0,     0,     'h01E, 'h004, 3, 1, 0));
        tbl.push_back(v(O,             0,     0,     'h020, 'h003, 2, 1, 0));
        tbl.push_back(v(O,             0,     0,     'h022, 'h002, 1, 1, 0));
        tbl.push_back(v(O,             0,     0,     'h024, 'h002, 0, 1, 0));
        tbl.push_back(v(R,             0,     0,     'h002, 'h002, 0, 1, 1));
        tbl.push_back(v(F,             0,     0,     'h004, 'h002, 0, 0, 0));
        tbl.push_back(v(B,             'hFFE, 0,     'hFFE, 'h002, 0, 0, 0));
        tbl.push_back(v(0,             0,     0,     'h000, 'h002, 0, 0, 0));
        tbl.push_back(v(S,             0,     0,     'h000, 'h002, 0, 0, 0));
        tbl.push_back(v(S|C|F,         'h123, 0,     'h000, 'h002, 0, 0, 0));
        tbl.push_back(v(0,             0,     0,     'h002, 'h002, 0, 0, 0));
        tbl.push_back(v(R|C|B|P|O,     'h300, 'h007, 'h002, 'h002, 0, 0, 1));
        tbl.push_back(v(C|B|P|O,       'h300, 'h007, 'h300, 'h004, 1, 0, 1));
        tbl.push_back(v(B|P|O,         'h0AA, 'h007, 'h0AA, 'h004, 1, 0, 1));
        tbl.push_back(v(P|O,           0,     'h007, 'h0AC, 'h002, 0, 0, 1));
        tbl.push_back(v(P|F,           0,     'h055, 'h0AE, 'h055, 1, 0, 0));
        tbl.push_back(v(R|F,           0,     0,     'h055, 'h002, 0, 0, 0));
        tbl.push_back(v(O|F,           0,     0,     'h057, 'h002, 0, 0, 0));
        tbl.push_back(v(O,             0,     0,     'h059, 'h002, 0, 0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            if (i == 0) reset = 1'b0;
            apply(tbl[i].cmd, tbl[i].tgt, tbl[i].pd);
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_top, tbl[i].e_dep,
                         tbl[i].e_ovf, tbl[i].e_unf);
        end

        // asynchronous reset in the middle of a call at depth 3
        @(negedge clk);
        reset = 1'b1;
        apply(0, 0, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(C, 'h100 * (i + 1), 0);
            @(posedge clk);
        end
        #1 check("pre_reset/depth", int'(depth), 3);
        @(negedge clk);
        apply(C, 'h400, 0);
        #2 reset = 1'b1;
        #1 check_all("midreset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 check_all("reset_hold", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        apply(0, 0, 0);
        @(posedge clk);
        #1 check_all("post_reset", 'h002, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            apply(O, 0, 0);
            @(posedge clk);
            #1 check_all($sformatf("cleared_lvl%0d", i), 'h004 + 2 * i, 0, 0, 0, 1);
        end

        // random traffic against the model
        @(negedge clk);
        reset = 1'b1;
        apply(0, 0, 0);
        m_reset();
        #1 check_all("rnd_reset", 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reset = 1'b0;
            cmd = 0;
            if ($urandom_range(0, 99) < 10) cmd |= S;
            if ($urandom_range(0, 99) < 8)  cmd |= B;
            if ($urandom_range(0, 99) < 10) cmd |= C;
            if ($urandom_range(0, 99) < 10) cmd |= R;
            if ($urandom_range(0, 99) < 25) cmd |= P;
            if ($urandom_range(0, 99) < 18) cmd |= O;
            if ($urandom_range(0, 99) < 8)  cmd |= F;
            tgt = int'($urandom_range(0, (1 << AW) - 1));
            pd  = int'($urandom_range(0, (1 << AW) - 1));
            apply(cmd, tgt, pd);
            m_step(cmd, tgt, pd);
            @(posedge clk);
            #1 check_all($sformatf("rnd%0d", n), m_pc, m_stk[0], m_dep, m_ovf, m_unf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 12: program-address width.
REQ-002 Parameter DEPTH, default 4: hardware stack levels.
REQ-003 Parameter STEP, default 2: sequential PC increment.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold all state this cycle; commands ignored.
REQ-007 branch_en  input  1  load PC from target.
REQ-008 call_en  input  1  push return address, load PC from target.
REQ-009 ret_en  input  1  load PC from stack top, pop.
REQ-010 push_en  input  1  push push_data; PC advances.
REQ-011 pop_en  input  1  pop; PC advances.
REQ-012 target  input  AW  branch/call destination.
REQ-013 push_data  input  AW  value pushed by push_en (accumulator low bits).
REQ-014 flag_clear  input  1  clear sticky flags (macro-dependent).
REQ-015 pc  output  AW  current fetch address to instruction memory.
REQ-016 stack_top  output  AW  combinational view of stack level 0.
REQ-017 depth  output  clog2(DEPTH)+1  valid entries, 0..DEPTH.
REQ-018 overflow  output  1  sticky: push/call issued while full.
REQ-019 underflow  output  1  sticky: pop/ret issued while empty.

Function
REQ-020 Stack SHALL be a shift register: level 0 is top; push shifts levels down, pop shifts levels up.
REQ-021 Command priority when several asserted SHALL be ret > call > branch > pop > push; lower-priority commands are ignored that cycle.
REQ-022 No command, stall low: pc SHALL become pc+STEP modulo 2^AW (0xFFE -> 0x000 at AW=12, STEP=2).
REQ-023 branch_en: pc SHALL become target next edge; stack unchanged.
REQ-024 call_en: level 0 SHALL receive pc+STEP, pc SHALL become target, depth increments (saturating at DEPTH).
REQ-025 ret_en: pc SHALL become stack_top, stack pops, depth decrements (saturating at 0).
REQ-026 push_en: level 0 SHALL receive push_data, pc advances by STEP.
REQ-027 pop_en: stack pops, pc advances by STEP; popped value is stack_top during the command cycle.
REQ-028 Push/call while depth==DEPTH: deepest entry SHALL be discarded, depth stays DEPTH.
REQ-029 Pop shifts SHALL copy level DEPTH-1 into itself (bottom retained).
REQ-030 Pop/ret while depth==0: shift still occurs, depth stays 0, ret loads stack_top.
REQ-031 stall high: pc, stack, depth, flags SHALL hold; stall dominates all commands and flag_clear.
REQ-032 Command-to-pc latency SHALL be exactly one clock edge.

Reset
REQ-033 reset high SHALL immediately force pc=0, all stack levels=0, depth=0, overflow=0, underflow=0, independent of clk.
REQ-034 Commands coincident with or in flight at reset SHALL be discarded; first post-reset edge with reset low performs normal update from pc=0.

Configuration
REQ-035 Macro PC_STACK_FLAGS_EN defined: overflow set per REQ-028, underflow per REQ-030, both sticky until flag_clear (clear wins over a simultaneous set).
REQ-036 Macro PC_STACK_FLAGS_EN undefined: overflow and underflow SHALL be constant 0, flag_clear ignored; all other behaviour identical.

Verification
REQ-037 Release reset, 3 idle cycles -> pc 0x000, 0x002, 0x004, 0x006; depth 0.
REQ-038 At pc=0x010 call_en target=0x100; next cycle ret_en -> pc 0x100 then 0x012; stack_top 0x012 then 0x000 (bottom-copied zero); depth 1 then 0.
REQ-039 Five push_en with 0x001..0x005 -> depth 4, stack_top 0x005, pops return 0x005,0x004,0x003,0x002; overflow=1 (flags build).
REQ-040 ret_en at depth 0 -> depth 0, underflow=1 (flags build) / 0 (no-flags build); flag_clear -> underflow 0.
REQ-041 branch_en target=0xFFE, idle, stall 2 cycles, idle -> pc 0xFFE, 0x000, 0x000, 0x000, 0x002.
REQ-042 Assert reset asynchronously mid-cycle during a call with depth 3 -> pc, depth, stack, flags zero before next edge.
